// File: rtl/irq_pending_latch_pkg.sv
// Shared constants, FSM state type and priority-select helper for the IRQ pending latch.
package irq_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Highest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [IDX_W-1:0] prio_idx(input logic [N_REQ-1:0] v);
        prio_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) prio_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Valid/ack handshake carrying the selected request index to the consumer.
interface irq_pending_latch_if;
    import irq_pkg::*;

    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             ack;

    modport master (output valid, output idx, input ack);
    modport slave  (input valid, input idx, output ack);
endinterface

// File: rtl/irq_pending_latch_sync.sv
// One request line: SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
module req_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending latch with priority select and valid/ack presentation.
// Optional mask register enabled by defining IRQ_MASK_EN.
//
// state   | meaning
// IDLE    | nothing presented; loads highest effective pending bit when nonzero
// PRESENT | irq_idx/irq_valid held until the consumer acks
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     i_req_in,
    input  logic                 i_clr_all,
`ifdef IRQ_MASK_EN
    input  logic                 i_mask_we,
    input  logic [N_REQ-1:0]     i_mask_wdata,
`endif
    output logic [N_REQ-1:0]     o_pending,
    output logic                 o_none_pending,
    irq_pending_latch_if.master  irq
);

    logic [N_REQ-1:0] w_rise;
    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_mask_nxt;
    logic [N_REQ-1:0] w_eff;
    logic [N_REQ-1:0] w_ack_clr;
    logic [N_REQ-1:0] w_pending_nxt;

    logic [N_REQ-1:0] r_pending;
    logic             r_none;
    state_t           r_state;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_sync
        req_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .i_req  (i_req_in[g]),
            .o_rise (w_rise[g])
        );
    end

`ifdef IRQ_MASK_EN
    logic [N_REQ-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst) r_mask <= '1;
        else if (i_mask_we) r_mask <= i_mask_wdata;
    end

    assign w_mask     = r_mask;
    assign w_mask_nxt = i_mask_we ? i_mask_wdata : r_mask;
`else
    assign w_mask     = '1;
    assign w_mask_nxt = '1;
`endif

    assign w_eff     = r_pending & w_mask;
    assign w_ack_clr = (r_state == PRESENT && irq.ack) ? (N_REQ'(1) << r_idx) : '0;
    // A rise on the bit being acked wins: the new event must not be lost.
    assign w_pending_nxt = i_clr_all ? '0 : ((r_pending & ~w_ack_clr) | w_rise);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_none    <= 1'b1;
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_none    <= ~|(w_pending_nxt & w_mask_nxt);
            if (i_clr_all) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (|w_eff) begin
                            r_idx   <= prio_idx(w_eff);
                            r_valid <= 1'b1;
                            r_state <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (irq.ack) begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_pending      = r_pending;
    assign o_none_pending = r_none;
    assign irq.valid      = r_valid;
    assign irq.idx        = r_idx;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: per-cycle vector table plus hand-written corner sequences.
module tb_irq_pending_latch;
    import irq_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req_in = 4'h0;
    logic             clr_all = 1'b0;
    logic             mask_we = 1'b0;
    logic [3:0]       mask_wdata = 4'h0;
    logic [3:0]       pending;
    logic             none_pending;

    irq_pending_latch_if u_if ();

    irq_pending_latch #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_in       (req_in),
        .i_clr_all      (clr_all),
`ifdef IRQ_MASK_EN
        .i_mask_we      (mask_we),
        .i_mask_wdata   (mask_wdata),
`endif
        .o_pending      (pending),
        .o_none_pending (none_pending),
        .irq            (u_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] idx;
        logic [3:0] pend;
        logic       none;
        logic       chk_idx;
        string      name;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       ev;
        logic [1:0] ei;
        logic [3:0] ep;
        logic       en;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] req, input logic clr, input logic ack, input logic rs,
                        input logic mwe, input logic [3:0] mwd,
                        input logic ev, input logic [1:0] ei, input logic [3:0] ep, input logic en,
                        input string nm);
        exp_t e;
        exp_t g;
        @(negedge clk);
        req_in     = req;
        clr_all    = clr;
        u_if.ack   = ack;
        rst        = rs;
        mask_we    = mwe;
        mask_wdata = mwd;
        e.valid = ev; e.idx = ei; e.pend = ep; e.none = en; e.chk_idx = ev | rs; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        cmp({g.name, " valid"}, {3'b0, u_if.valid}, {3'b0, g.valid});
        if (g.chk_idx) cmp({g.name, " idx"}, {2'b0, u_if.idx}, {2'b0, g.idx});
        cmp({g.name, " pending"}, pending, g.pend);
        cmp({g.name, " none_pending"}, {3'b0, none_pending}, {3'b0, g.none});
    endtask

    task automatic idle(input int n, input logic [3:0] req, input string nm);
        for (int k = 0; k < n; k++) step(req, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, nm);
    endtask

    task automatic plain(input logic [3:0] req, input logic ack, input logic ev, input logic [1:0] ei,
                         input logic [3:0] ep, input logic en, input string nm);
        step(req, 1'b0, ack, 1'b0, 1'b0, 4'h0, ev, ei, ep, en, nm);
    endtask

    initial begin
        u_if.ack = 1'b0;
        // req, ack, valid, idx, pending, none_pending
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b1011, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b1011, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b1011, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0});
        tbl.push_back('{4'b1011, 1'b0, 1'b1, 2'd3, 4'b1011, 1'b0});
        tbl.push_back('{4'b1011, 1'b1, 1'b0, 2'd0, 4'b0011, 1'b0});
        tbl.push_back('{4'b1011, 1'b1, 1'b1, 2'd1, 4'b0011, 1'b0}); // ack during IDLE gap ignored
        tbl.push_back('{4'b1011, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1011, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 1'b1, 2'd0, 4'b1001, 1'b0}); // no preemption
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0});
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});

        step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, "reset");
        step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, "reset");

        foreach (tbl[i])
            plain(tbl[i].req, tbl[i].ack, tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].en, $sformatf("vec%0d", i));

        // Long hold on line 2: exactly one event.
        for (int c = 0; c < 20; c++)
            plain(4'b0100, 1'b0, c >= 3, 2'd2, (c >= 2) ? 4'b0100 : 4'b0000, c < 2, "hold");
        plain(4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, "hold_ack");
        idle(3, 4'b0100, "hold_after");
        idle(3, 4'b0000, "hold_drop");

        // Re-raise, then a fresh rise coinciding with the ack of the same bit.
        plain(4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "rerise");
        plain(4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "rerise");
        plain(4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, "rerise");
        plain(4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, "rerise");
        for (int c = 0; c < 3; c++) plain(4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, "rr_drop");
        plain(4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, "rr_up");
        plain(4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, "rr_up");
        plain(4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b0, "ack_and_rise");
        plain(4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, "ack_and_rise_next");
        plain(4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, "ack_and_rise_done");
        idle(3, 4'b0000, "rr_end");

        // clr_all while presenting; synchroniser keeps the held lines, so no new event.
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "clr_setup");
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "clr_setup");
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0110, 1'b0, "clr_setup");
        plain(4'b0110, 1'b0, 1'b1, 2'd2, 4'b0110, 1'b0, "clr_setup");
        step(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'b0000, 1'b1, "clr_all");
        idle(3, 4'b0110, "clr_after");
        idle(3, 4'b0000, "clr_drop");

        // rst mid-handshake; held lines re-detected as new rises afterwards.
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "rst_setup");
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "rst_setup");
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0110, 1'b0, "rst_setup");
        plain(4'b0110, 1'b0, 1'b1, 2'd2, 4'b0110, 1'b0, "rst_setup");
        step(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'b0000, 1'b1, "rst_mid");
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "rst_after");
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "rst_after");
        plain(4'b0110, 1'b0, 1'b0, 2'd0, 4'b0110, 1'b0, "rst_after");
        plain(4'b0110, 1'b0, 1'b1, 2'd2, 4'b0110, 1'b0, "rst_after");
        plain(4'b0110, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, "rst_ack2");
        plain(4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, "rst_pres1");
        plain(4'b0110, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, "rst_ack1");
        idle(3, 4'b0000, "rst_drop");

`ifdef IRQ_MASK_EN
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 2'd0, 4'b0000, 1'b1, "mask_wr");
        plain(4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "masked");
        plain(4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "masked");
        plain(4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, "masked");
        plain(4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, "masked");
        plain(4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, "masked");
        step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 4'b1000, 1'b0, "unmask");
        plain(4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, "unmasked_pres");
        plain(4'b1000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, "unmasked_ack");
        idle(3, 4'b0000, "mask_drop");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream stage for the 4-to-2 priority encoder.
- Synchronises 4 raw request lines, detects rising edges and latches them as sticky pending bits.
- Selects the highest-priority pending request and presents its 2-bit index through a valid/ack handshake.
- Clears each pending bit only when the consumer acknowledges it. Priority order matches the encoder: bit 3 highest, bit 0 lowest.

Parameters:
- N_REQ, 4: number of request lines. Fixed at 4 for this revision.
- IDX_W, 2: index width, equal to clog2(N_REQ).
- SYNC_STAGES, 2: synchroniser flops per request line. Minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N_REQ  raw request lines, asynchronous to clk, rising-edge significant.
- clr_all  input  1  synchronous clear of all pending bits.
- irq_ack  input  1  consumer accepts the presented index.
- irq_valid  output  1  irq_idx is valid.
- irq_idx  output  IDX_W  index of the selected request.
- pending  output  N_REQ  current pending register.
- none_pending  output  1  high when the effective pending vector is zero.

Behaviour:
- Reset values, on the rst-high edge:
  - sync chain 0, edge-detect history 0, pending 0.
  - FSM IDLE, irq_valid 0, irq_idx 0, none_pending 1.
- Edge detect:
  - rise[i] = sync_out[i] & ~sync_prev[i].
  - A line held high sets pending exactly once; it must go low and high again to re-request.
- Latency: counting the first clk edge that samples req_in high as edge 0 (SYNC_STAGES=2):
  - pending set at edge 2;
  - irq_valid high after edge 3.
- Pending update priority, highest first: rst > clr_all > set from rise > clear from ack.
  - Same bit rising and being acked in the same cycle: bit stays set (new event is kept).
- FSM IDLE:
  - if effective pending is nonzero, load irq_idx with the highest set bit, assert irq_valid, go to PRESENT.
  - otherwise irq_valid stays 0.
- FSM PRESENT:
  - irq_idx and irq_valid held stable; no preemption by later higher-priority arrivals.
  - on irq_ack: clear pending[irq_idx], deassert irq_valid, go to IDLE.
  - every ack is followed by a mandatory one-cycle IDLE gap before the next presentation.
- irq_ack while in IDLE: ignored.
- clr_all in any state: pending goes to 0, FSM to IDLE, irq_valid to 0 next cycle. Synchroniser contents are kept.
- rst mid-handshake: everything returns to reset values; pending events are lost.
- none_pending = ~|effective_pending, registered together with pending.

Optional Feature:
- Macro IRQ_MASK_EN.
- Defined:
  - adds inputs mask_we (1 bit) and mask_wdata (N_REQ bits), plus an internal mask register, reset value all ones.
  - effective_pending = pending & mask.
  - masked bits still latch but are never selected.
  - masking the currently presented bit does not withdraw it.
- Undefined:
  - no mask ports or register; effective_pending = pending.

Decomposition:
- Shared package irq_pkg:
  - N_REQ and IDX_W constants.
  - FSM state enum {IDLE, PRESENT}.
  - prio index function (highest set bit wins, returns 0 for an all-zero vector).
- One sub-module, req_sync_edge:
  - per-line SYNC_STAGES synchroniser plus rising-edge detector;
  - instantiated as a vector of N_REQ lines.

Test Plan:
- Reset then req_in=0001, held high -> pending=0001 at edge 2; irq_valid=1, irq_idx=00 after edge 3; ack -> pending=0000, irq_valid=0.
- req_in 0000 -> 1011 in one cycle -> idx 11 first; after ack, one-cycle gap, then idx 01, then idx 00; none_pending=1 at the end.
- Present idx=00, then raise req_in[3] -> idx stays 00 until ack; the next presentation is idx 11.
- Hold req_in[2] high for 20 cycles -> only one pending event. Drop it and raise it again -> second event; ack and rise in the same cycle leaves pending[2]=1.
- clr_all during PRESENT with pending=0110 -> pending=0000 and irq_valid=0 next cycle. rst asserted mid-handshake gives the same result.
- IRQ_MASK_EN build: write mask=0111, then req_in=1000 -> pending=1000, irq_valid stays 0. Write mask=1111 -> idx 11 is presented.
